// File: rtl/dma_pkg.sv
// Shared types and defaults for the CPU-side DMA bus-request controller.
package dma_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned BLOCK_SIZE = 64;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned DMA_LEN    = 12;
    localparam logic [15:0] DMA_ADDR   = 16'h01F4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_BR = 3'd2,
        GRANTED = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/dma_bus_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dma_bus_ctrl.sv
// CPU-side DMA bus-request controller: issues DMA commands, arbitrates the
// data-memory bus (BR/BG), and reports completion with debug statistics.
module dma_bus_ctrl #(
    parameter int unsigned          WORD_SIZE = dma_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] DMA_ADDR  = WORD_SIZE'(dma_pkg::DMA_ADDR),
    parameter int unsigned          DMA_LEN   = dma_pkg::DMA_LEN,
    parameter int unsigned          CNT_W     = dma_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dma_start_int,
    input  logic                 BR,
    input  logic                 dma_end_int,
    input  logic                 cpu_mem_busy,
    output logic                 cmd,
    output logic [WORD_SIZE-1:0] cmd_addr,
    output logic [WORD_SIZE-1:0] cmd_len,
    output logic                 BG,
    output logic                 cpu_stall,
    output logic                 done_int,
    output logic                 overrun,
    output logic [CNT_W-1:0]     grant_cycles,
    output logic [7:0]           xfer_count
);

    import dma_pkg::*;

    state_t               r_state;
    logic                 r_pending;
    logic                 r_overrun;
    logic                 r_cmd;
    logic [WORD_SIZE-1:0] r_cmd_addr;
    logic [WORD_SIZE-1:0] r_cmd_len;
    logic                 r_bg;
    logic                 r_stall;
    logic                 r_done;
    logic [7:0]           r_xfer;

    state_t               w_state_nxt;
    logic                 w_pending_nxt;
    logic                 w_overrun_nxt;
    logic                 w_cmd_nxt;
    logic                 w_bg_nxt;
    logic                 w_stall_nxt;
    logic                 w_done_nxt;
    logic [7:0]           w_xfer_nxt;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_cmd      <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_bg       <= 1'b0;
            r_stall    <= 1'b0;
            r_done     <= 1'b0;
            r_xfer     <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_overrun  <= w_overrun_nxt;
            r_cmd      <= w_cmd_nxt;
            r_cmd_addr <= w_cmd_nxt ? DMA_ADDR : '0;
            r_cmd_len  <= w_cmd_nxt ? WORD_SIZE'(DMA_LEN) : '0;
            r_bg       <= w_bg_nxt;
            r_stall    <= w_stall_nxt;
            r_done     <= w_done_nxt;
            r_xfer     <= w_xfer_nxt;
        end
    end

    // Next-state, request bookkeeping and next output values.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        w_xfer_nxt    = r_xfer;

        unique case (r_state)
            IDLE: begin
                if (dma_start_int || r_pending) begin
                    w_state_nxt   = ISSUE;
                    w_pending_nxt = 1'b0;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_BR;
            end
            WAIT_BR: begin
                if (BR && !cpu_mem_busy) begin
                    w_state_nxt = GRANTED;
                end
            end
            GRANTED: begin
                if (dma_end_int) begin
                    w_state_nxt = DONE;
                end else if (!BR) begin
                    w_state_nxt = WAIT_BR;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_xfer_nxt  = r_xfer + 8'd1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A start outside IDLE is queued; a second one while queued is lost.
        if (dma_start_int && (r_state != IDLE)) begin
            if (r_pending) begin
                w_overrun_nxt = 1'b1;
            end
            w_pending_nxt = 1'b1;
        end

        w_cmd_nxt   = (w_state_nxt == ISSUE);
        w_bg_nxt    = (w_state_nxt == GRANTED);
        w_stall_nxt = w_bg_nxt || ((w_state_nxt == WAIT_BR) && BR);
        w_done_nxt  = (r_state == DONE);
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_grant_cnt (
        .clk     (clk),
        .i_clr   (!reset_n),
        .i_en    (r_bg),
        .o_count (grant_cycles)
    );

    assign cmd        = r_cmd;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_len    = r_cmd_len;
    assign BG         = r_bg;
    assign cpu_stall  = r_stall;
    assign done_int   = r_done;
    assign overrun    = r_overrun;
    assign xfer_count = r_xfer;

endmodule

// File: tb/tb_dma_bus_ctrl.sv
// Directed self-checking bench for dma_bus_ctrl (default build plus a 4-bit counter build).
module tb_dma_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dma_start_int;
    logic        BR;
    logic        dma_end_int;
    logic        cpu_mem_busy;

    logic        cmd, BG, cpu_stall, done_int, overrun;
    logic [15:0] cmd_addr, cmd_len, grant_cycles;
    logic [7:0]  xfer_count;

    logic        cmd4, BG4, cpu_stall4, done_int4, overrun4;
    logic [15:0] cmd_addr4, cmd_len4;
    logic [3:0]  grant_cycles4;
    logic [7:0]  xfer_count4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_bus_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dma_start_int (dma_start_int),
        .BR            (BR),
        .dma_end_int   (dma_end_int),
        .cpu_mem_busy  (cpu_mem_busy),
        .cmd           (cmd),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .BG            (BG),
        .cpu_stall     (cpu_stall),
        .done_int      (done_int),
        .overrun       (overrun),
        .grant_cycles  (grant_cycles),
        .xfer_count    (xfer_count)
    );

    dma_bus_ctrl #(.CNT_W(4)) dut4 (
        .clk           (clk),
        .reset_n       (reset_n),
        .dma_start_int (dma_start_int),
        .BR            (BR),
        .dma_end_int   (dma_end_int),
        .cpu_mem_busy  (cpu_mem_busy),
        .cmd           (cmd4),
        .cmd_addr      (cmd_addr4),
        .cmd_len       (cmd_len4),
        .BG            (BG4),
        .cpu_stall     (cpu_stall4),
        .done_int      (done_int4),
        .overrun       (overrun4),
        .grant_cycles  (grant_cycles4),
        .xfer_count    (xfer_count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dma_start_int = 1'b0; BR = 1'b0;
        dma_end_int = 1'b0; cpu_mem_busy = 1'b0;
        step(); step();
        reset_n = 1'b1;
        n_vec++;
        if ({cmd, BG, cpu_stall, done_int, overrun} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000", {cmd, BG, cpu_stall, done_int, overrun});
        end
        n_vec++;
        if ({cmd_addr, cmd_len, grant_cycles, xfer_count} !== 56'd0) begin
            n_err++; $display("FAIL reset_values: got %h expected 0", {cmd_addr, cmd_len, grant_cycles, xfer_count});
        end
    endtask

    task automatic test_basic();
        dma_start_int = 1'b1;                 // cycle 0
        step();                               // cycle 1
        dma_start_int = 1'b0;
        n_vec++;
        if (cmd !== 1'b1 || cmd_addr !== 16'h01F4 || cmd_len !== 16'd12) begin
            n_err++; $display("FAIL basic_cmd: got cmd=%b addr=%h len=%0d expected 1 01f4 12", cmd, cmd_addr, cmd_len);
        end
        step();                               // cycle 2
        n_vec++;
        if (cmd !== 1'b0 || cmd_addr !== 16'h0 || cmd_len !== 16'h0) begin
            n_err++; $display("FAIL basic_cmd_clear: got cmd=%b addr=%h len=%h expected 0 0 0", cmd, cmd_addr, cmd_len);
        end
        step();                               // cycle 3
        n_vec++;
        if (BG !== 1'b0) begin
            n_err++; $display("FAIL basic_bg_early: got %b expected 0", BG);
        end
        BR = 1'b1;
        for (int c = 4; c <= 15; c++) begin
            step();
            n_vec++;
            if (BG !== 1'b1) begin
                n_err++; $display("FAIL basic_bg_c%0d: got %b expected 1", c, BG);
            end
            if (c == 15) begin
                BR = 1'b0; dma_end_int = 1'b1;
            end
        end
        step();                               // cycle 16
        dma_end_int = 1'b0;
        n_vec++;
        if (BG !== 1'b0 || done_int !== 1'b0) begin
            n_err++; $display("FAIL basic_c16: got bg=%b done=%b expected 0 0", BG, done_int);
        end
        step();                               // cycle 17
        n_vec++;
        if (done_int !== 1'b1 || xfer_count !== 8'd1 || grant_cycles !== 16'd12) begin
            n_err++; $display("FAIL basic_done: got done=%b xfer=%0d grant=%0d expected 1 1 12", done_int, xfer_count, grant_cycles);
        end
        step();
        n_vec++;
        if (done_int !== 1'b0) begin
            n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done_int);
        end
    endtask

    task automatic test_busy_deferral();
        int ndone;
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        step();                               // WAIT_BR
        BR = 1'b1; cpu_mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (BG !== 1'b0 || cpu_stall !== 1'b1) begin
                n_err++; $display("FAIL busy_hold_%0d: got bg=%b stall=%b expected 0 1", k, BG, cpu_stall);
            end
        end
        cpu_mem_busy = 1'b0;
        step();
        n_vec++;
        if (BG !== 1'b1 || cpu_stall !== 1'b1) begin
            n_err++; $display("FAIL busy_grant: got bg=%b stall=%b expected 1 1", BG, cpu_stall);
        end
        BR = 1'b0; dma_end_int = 1'b1;
        step();
        dma_end_int = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done_int === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone != 1 || xfer_count !== 8'd2 || grant_cycles !== 16'd13) begin
            n_err++; $display("FAIL busy_done: got ndone=%0d xfer=%0d grant=%0d expected 1 2 13", ndone, xfer_count, grant_cycles);
        end
    endtask

    task automatic test_cycle_steal();
        logic [11:0] br_pat  = 12'b000_1111_00_1111;   // bit k = BR driven in cycle k
        logic [11:0] bg_exp  = 12'b0111_1001_1110;     // bit k = BG expected in cycle k
        int ndone;
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        step();
        for (int k = 0; k < 12; k++) begin
            n_vec++;
            if (BG !== bg_exp[k]) begin
                n_err++; $display("FAIL steal_bg_c%0d: got %b expected %b", k, BG, bg_exp[k]);
            end
            BR = br_pat[k];
            dma_end_int = (k == 10);
            step();
        end
        dma_end_int = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            if (done_int === 1'b1) ndone++;
            step();
        end
        n_vec++;
        if (ndone != 1 || grant_cycles !== 16'd21 || xfer_count !== 8'd3) begin
            n_err++; $display("FAIL steal_done: got ndone=%0d grant=%0d xfer=%0d expected 1 21 3", ndone, grant_cycles, xfer_count);
        end
    endtask

    task automatic test_pending_overrun();
        bit seen;
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        step();
        BR = 1'b1;
        step(); step();                       // GRANTED
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++; $display("FAIL pend_first: got overrun=%b expected 0", overrun);
        end
        step();
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++; $display("FAIL pend_overrun: got %b expected 1", overrun);
        end
        BR = 1'b0; dma_end_int = 1'b1;
        step();                               // DONE
        dma_end_int = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            step();
            if (cmd === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen || overrun !== 1'b1) begin
            n_err++; $display("FAIL pend_reissue: got cmd_seen=%b overrun=%b expected 1 1", seen, overrun);
        end
    endtask

    task automatic test_reset_mid_grant();
        int nbad;
        step();                               // leave ISSUE for WAIT_BR
        BR = 1'b1;
        step();
        n_vec++;
        if (BG !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_bg: got %b expected 1", BG);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_vec++;
        if ({BG, cpu_stall, cmd, done_int, overrun} !== 5'b0 || grant_cycles !== 16'd0 || xfer_count !== 8'd0 || grant_cycles4 !== 4'd0) begin
            n_err++; $display("FAIL rst_mid: got flags=%b grant=%0d xfer=%0d grant4=%0d expected 0", {BG, cpu_stall, cmd, done_int, overrun}, grant_cycles, xfer_count, grant_cycles4);
        end
        nbad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (BG !== 1'b0 || done_int !== 1'b0) nbad++;
        end
        n_vec++;
        if (nbad != 0) begin
            n_err++; $display("FAIL rst_spurious_br: got %0d bad cycles expected 0", nbad);
        end
        BR = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        step();
        BR = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 9) begin
                n_vec++;
                if (grant_cycles4 !== 4'd9) begin
                    n_err++; $display("FAIL sat_mid: got %0d expected 9", grant_cycles4);
                end
            end
        end
        BR = 1'b0; dma_end_int = 1'b1;
        step();
        dma_end_int = 1'b0;
        step();
        n_vec++;
        if (grant_cycles4 !== 4'hF || grant_cycles !== 16'd20) begin
            n_err++; $display("FAIL sat_final: got grant4=%h grant=%0d expected f 20", grant_cycles4, grant_cycles);
        end
        n_vec++;
        if (xfer_count !== 8'd1 || done_int !== 1'b1) begin
            n_err++; $display("FAIL sat_done: got xfer=%0d done=%b expected 1 1", xfer_count, done_int);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_deferral();
        test_cycle_steal();
        test_pending_overrun();
        test_reset_mid_grant();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
